// File: rtl/lives_manager.sv
// lives_manager: player life tracking with post-hit invulnerability window and optional blink.
// Ports: clk, reset (async, active-high); startOfFrame/newGame/hit/bonus event pulses;
//        lives (thermometer mask), livesDisplay (mask for bitmap stage), invulnerable, gameOver.
// Optional feature macro: LIVES_BLINK_EN (blinks the just-lost life during invulnerability).
module lives_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int INVULN_FRAMES = 64,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       newGame,
    input  logic       hit,
    input  logic       bonus,
    output logic [2:0] lives,
    output logic [2:0] livesDisplay,
    output logic       invulnerable,
    output logic       gameOver
);
    typedef enum logic [1:0] {IDLE, PLAYING, INVULN, GAME_OVER} state_t;
    localparam logic [2:0] LIVES_INIT = 3'((1 << INIT_LIVES) - 1);
    if (INIT_LIVES < 1 || INIT_LIVES > 3 || INVULN_FRAMES < 1 || INVULN_FRAMES > 127 ||
        BLINK_FRAMES < 1 || BLINK_FRAMES > 127) begin : g_bad_param
        $error("lives_manager: parameter out of legal range");
    end
    state_t     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [6:0] cnt_q, cnt_d;
    logic [2:0] disp_q, disp_d;
    logic       inv_q, inv_d;
    logic       go_q, go_d;
`ifdef LIVES_BLINK_EN
    logic [2:0] lost_q, lost_d;
    logic [6:0] bcnt_q, bcnt_d;
    logic       phase_q, phase_d;
`endif
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
`ifdef LIVES_BLINK_EN
        lost_d  = lost_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
`endif
        if (newGame) begin
            state_d = PLAYING;
            lives_d = LIVES_INIT;
            cnt_d   = '0;
`ifdef LIVES_BLINK_EN
            lost_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
`endif
        end else if (state_q == PLAYING && hit) begin
            // A simultaneous bonus is dropped in favour of the hit.
            lives_d = lives_q >> 1;
            if (lives_d == 3'b000) begin
                state_d = GAME_OVER;
            end else begin
                state_d = INVULN;
                cnt_d   = 7'(INVULN_FRAMES);
`ifdef LIVES_BLINK_EN
                lost_d  = lives_q & ~lives_d;
                bcnt_d  = '0;
                phase_d = 1'b0;
`endif
            end
        end else begin
            if ((state_q == PLAYING || state_q == INVULN) && bonus)
                lives_d = {lives_q[1:0], 1'b1};
            if (state_q == INVULN && startOfFrame && cnt_q != '0) begin
                cnt_d = cnt_q - 7'd1;
                if (cnt_d == '0)
                    state_d = PLAYING;
`ifdef LIVES_BLINK_EN
                bcnt_d  = (bcnt_q == 7'(BLINK_FRAMES - 1)) ? '0 : bcnt_q + 7'd1;
                phase_d = (bcnt_q == 7'(BLINK_FRAMES - 1)) ? ~phase_q : phase_q;
`endif
            end
        end
        inv_d  = state_d == INVULN;
        go_d   = state_d == GAME_OVER;
`ifdef LIVES_BLINK_EN
        disp_d = lives_d | ((inv_d && !phase_d) ? lost_d : 3'b000);
`else
        disp_d = lives_d;
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lives_q <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            inv_q   <= 1'b0;
            go_q    <= 1'b0;
`ifdef LIVES_BLINK_EN
            lost_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            inv_q   <= inv_d;
            go_q    <= go_d;
`ifdef LIVES_BLINK_EN
            lost_q  <= lost_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
`endif
        end
    end
    assign lives        = lives_q;
    assign livesDisplay = disp_q;
    assign invulnerable = inv_q;
    assign gameOver     = go_q;
endmodule

// File: tb/tb_lives_manager.sv
// tb_lives_manager: scenario and randomized checks of lives_manager against a life-count model.
module tb_lives_manager;
    localparam int INV_F = 64;
    localparam int BLK_F = 8;
`ifdef LIVES_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic startOfFrame = 1'b0, newGame = 1'b0, hit = 1'b0, bonus = 1'b0;
    logic [2:0] lives, livesDisplay;
    logic invulnerable, gameOver;
    int checks = 0;
    int passes = 0;
    // Model: life count, mode (0 idle, 1 playing, 2 invulnerable, 3 over), frames left, frames since hit.
    int m_n = 0, m_mode = 0, m_left = 0, m_elapsed = 0, m_lostn = 0;

    lives_manager #(.INIT_LIVES(3), .INVULN_FRAMES(INV_F), .BLINK_FRAMES(BLK_F)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .newGame(newGame),
        .hit(hit), .bonus(bonus), .lives(lives), .livesDisplay(livesDisplay),
        .invulnerable(invulnerable), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] mask(input int n);
        return 3'((1 << n) - 1);
    endfunction

    function automatic logic [7:0] model_vec();
        logic [2:0] d;
        d = mask(m_n);
        if (BLINK && m_mode == 2 && ((m_elapsed / BLK_F) % 2) == 0)
            d = d | 3'(1 << m_lostn);
        return {mask(m_n), d, m_mode == 2, m_mode == 3};
    endfunction

    task automatic model_update(input logic s, g, h, b);
        if (g) begin
            m_n = 3; m_mode = 1; m_left = 0;
        end else if (m_mode == 1 && h) begin
            m_n--;
            if (m_n == 0) m_mode = 3;
            else begin m_mode = 2; m_left = INV_F; m_elapsed = 0; m_lostn = m_n; end
        end else begin
            if ((m_mode == 1 || m_mode == 2) && b && m_n < 3) m_n++;
            if (m_mode == 2 && s) begin
                m_left--; m_elapsed++;
                if (m_left == 0) m_mode = 1;
            end
        end
    endtask

    task automatic step(input logic s, g, h, b);
        @(negedge clk);
        startOfFrame = s; newGame = g; hit = h; bonus = b;
        @(posedge clk);
        #1;
        model_update(s, g, h, b);
        startOfFrame = 1'b0; newGame = 1'b0; hit = 1'b0; bonus = 1'b0;
    endtask

    task automatic frames(input int k);
        for (int i = 0; i < k; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        m_n = 0; m_mode = 0; m_left = 0; m_elapsed = 0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({lives, livesDisplay, invulnerable, gameOver} !== 8'h00)
            $display("FAIL reset_async: got %b expected 00000000", {lives, livesDisplay, invulnerable, gameOver});
        else passes++;
        release_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({lives, livesDisplay, invulnerable, gameOver} !== 8'h00)
            $display("FAIL idle_ignores: got %b expected 00000000", {lives, livesDisplay, invulnerable, gameOver});
        else passes++;
    endtask

    task automatic test_new_game();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({lives, livesDisplay, invulnerable, gameOver} !== 8'b111_111_0_0)
            $display("FAIL new_game: got %b expected 11111100", {lives, livesDisplay, invulnerable, gameOver});
        else passes++;
    endtask

    task automatic test_hit_window();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({lives, invulnerable} !== 4'b011_1)
            $display("FAIL first_hit: got %b expected 0111", {lives, invulnerable});
        else passes++;
        frames(10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({lives, invulnerable} !== 4'b011_1)
            $display("FAIL hit_in_window: got %b expected 0111", {lives, invulnerable});
        else passes++;
        frames(INV_F - 11);
        checks++;
        if (invulnerable !== 1'b1)
            $display("FAIL window_end_minus1: got %b expected 1", invulnerable);
        else passes++;
        frames(1);
        checks++;
        if ({lives, livesDisplay, invulnerable} !== 7'b011_011_0)
            $display("FAIL window_end: got %b expected 0110110", {lives, livesDisplay, invulnerable});
        else passes++;
    endtask

    task automatic test_game_over();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        frames(INV_F);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({lives, invulnerable} !== 4'b001_1)
            $display("FAIL second_hit: got %b expected 0011", {lives, invulnerable});
        else passes++;
        frames(INV_F);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({lives, livesDisplay, invulnerable, gameOver} !== 8'b000_000_0_1)
            $display("FAIL game_over: got %b expected 00000001", {lives, livesDisplay, invulnerable, gameOver});
        else passes++;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({lives, livesDisplay, invulnerable, gameOver} !== 8'b000_000_0_1)
            $display("FAIL over_ignores: got %b expected 00000001", {lives, livesDisplay, invulnerable, gameOver});
        else passes++;
    endtask

    task automatic test_hit_bonus();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({lives, invulnerable} !== 4'b011_1)
            $display("FAIL hit_and_bonus: got %b expected 0111", {lives, invulnerable});
        else passes++;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({lives, invulnerable} !== 4'b111_0)
            $display("FAIL bonus_saturate: got %b expected 1110", {lives, invulnerable});
        else passes++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        frames(INV_F);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        frames(5);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({lives, invulnerable} !== 4'b011_1)
            $display("FAIL bonus_in_invuln: got %b expected 0111", {lives, invulnerable});
        else passes++;
        frames(INV_F - 6);
        checks++;
        if (invulnerable !== 1'b1)
            $display("FAIL bonus_keeps_counter: got %b expected 1", invulnerable);
        else passes++;
        frames(1);
        checks++;
        if (invulnerable !== 1'b0)
            $display("FAIL bonus_window_end: got %b expected 0", invulnerable);
        else passes++;
    endtask

    task automatic test_blink();
        logic [2:0] want;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int e = 0; e <= INV_F; e++) begin
            if (e > 0) frames(1);
            want = (BLINK && e < INV_F && ((e / BLK_F) % 2) == 0) ? 3'b111 : 3'b011;
            checks++;
            if (livesDisplay !== want)
                $display("FAIL blink_frame%0d: got %b expected %b", e, livesDisplay, want);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_invuln();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        frames(INV_F - 30);
        do_reset();
        checks++;
        if ({lives, livesDisplay, invulnerable, gameOver} !== 8'h00)
            $display("FAIL reset_mid_invuln: got %b expected 00000000", {lives, livesDisplay, invulnerable, gameOver});
        else passes++;
        release_reset();
        frames(40);
        checks++;
        if ({lives, livesDisplay, invulnerable, gameOver} !== 8'h00)
            $display("FAIL after_reset_frames: got %b expected 00000000", {lives, livesDisplay, invulnerable, gameOver});
        else passes++;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({lives, invulnerable, gameOver} !== 5'b111_0_0)
            $display("FAIL new_game_after_reset: got %b expected 11100", {lives, invulnerable, gameOver});
        else passes++;
    endtask

    task automatic test_random();
        logic s, g, h, b;
        logic [7:0] exp_v;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 1) == 0);
            g = ($urandom_range(0, 199) == 0);
            h = ($urandom_range(0, 29) == 0);
            b = ($urandom_range(0, 39) == 0);
            step(s, g, h, b);
            exp_v = model_vec();
            checks++;
            if ({lives, livesDisplay, invulnerable, gameOver} !== exp_v)
                $display("FAIL random_cycle%0d: got %b expected %b", i, {lives, livesDisplay, invulnerable, gameOver}, exp_v);
            else passes++;
        end
    endtask

    initial begin
        #1 test_reset();
        test_new_game();
        test_hit_window();
        test_game_over();
        test_hit_bonus();
        test_blink();
        test_reset_mid_invuln();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/lives_manager.md
LIVES_MANAGER -- requirements
Module: lives_manager

Interface
REQ-001 The block SHALL have parameter INIT_LIVES, default 3, giving lives granted on a new game (legal 1..3).
REQ-002 The block SHALL have parameter INVULN_FRAMES, default 64, giving the post-hit invulnerability length in frames (legal 1..127).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 8, giving the frames per blink half-period (legal 1..127).
REQ-004 The block SHALL have port clk, input, 1 bit, system clock.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port startOfFrame, input, 1 bit, one-cycle pulse per VGA frame.
REQ-007 The block SHALL have port newGame, input, 1 bit, one-cycle pulse that starts a game.
REQ-008 The block SHALL have port hit, input, 1 bit, one-cycle pulse when the player is struck.
REQ-009 The block SHALL have port bonus, input, 1 bit, one-cycle pulse that grants one extra life.
REQ-010 The block SHALL have port lives, output, 3 bits, thermometer life mask: 000, 001, 011 or 111.
REQ-011 The block SHALL have port livesDisplay, output, 3 bits, mask fed to the lives bitmap stage.
REQ-012 The block SHALL have port invulnerable, output, 1 bit, high while hits are ignored.
REQ-013 The block SHALL have port gameOver, output, 1 bit, high after the last life is lost.

Function
REQ-014 The block SHALL implement the states IDLE, PLAYING, INVULN and GAME_OVER.
REQ-015 All outputs SHALL be registered and SHALL reflect an input event on the clock edge after the event is sampled, giving 1-cycle latency.
REQ-016 A newGame pulse in any state SHALL set lives to the INIT_LIVES thermometer mask, clear the frame counter, clear gameOver and enter PLAYING; newGame SHALL override a simultaneous hit or bonus.
REQ-017 A hit in PLAYING SHALL shift lives right by one bit (111->011->001->000).
REQ-018 If a hit takes lives to 000, the block SHALL enter GAME_OVER and set gameOver=1; otherwise it SHALL enter INVULN and load the counter with INVULN_FRAMES.
REQ-019 In INVULN, each startOfFrame SHALL decrement the counter, and the block SHALL return to PLAYING on the startOfFrame that brings the counter to 0.
REQ-020 In INVULN, GAME_OVER and IDLE, hit SHALL be ignored.
REQ-021 A bonus in PLAYING or INVULN SHALL shift lives left with a 1 inserted, saturating at 111; a bonus at 111 is a no-op, and a bonus SHALL NOT alter the state or the counter.
REQ-022 A bonus in IDLE or GAME_OVER SHALL be ignored.
REQ-023 If hit and bonus arrive in the same cycle in PLAYING, the hit SHALL be processed and the bonus discarded.
REQ-024 invulnerable SHALL equal 1 exactly when the state is INVULN.
REQ-025 lives SHALL always be a legal thermometer value.
REQ-026 The counter SHALL be 7 bits wide and SHALL never underflow.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, lives=000, livesDisplay=000, invulnerable=0, gameOver=0, counter=0 and blink phase=0, independent of clk.
REQ-028 Reset asserted mid-INVULN or mid-GAME_OVER SHALL abandon that state without any residual pulse or countdown after release.
REQ-029 The block SHALL accept events starting on the first clk edge after reset is released.

Configuration
REQ-030 When the macro LIVES_BLINK_EN is defined, the block SHALL, during INVULN, show the just-lost life bit in livesDisplay OR-ed into lives, toggling every BLINK_FRAMES startOfFrame pulses, starting visible.
REQ-031 When LIVES_BLINK_EN is defined, livesDisplay SHALL equal lives outside INVULN.
REQ-032 When LIVES_BLINK_EN is not defined, livesDisplay SHALL equal lives at all times, and the blink logic SHALL be absent.

Verification
REQ-033 Scenario: reset, then newGame -> the cycle after newGame shows lives=111, PLAYING state and gameOver=0.
REQ-034 Scenario: hit at 111 -> lives=011 and invulnerable=1; after 64 startOfFrame pulses invulnerable=0; a second hit during the window leaves lives at 011.
REQ-035 Scenario: three hits, each separated by a full INVULN window -> lives goes 011, 001, 000; gameOver=1 on the cycle after the third hit; further hit and bonus cause no change.
REQ-036 Scenario: hit and bonus in the same cycle at 111 -> lives=011 and INVULN; bonus at 111 -> lives stays 111; bonus at 001 during INVULN -> lives=011 and invulnerable remains 1.
REQ-037 Scenario: with LIVES_BLINK_EN defined, hit at 111 -> livesDisplay=111 for 8 frames, then 011 for 8 frames, and so on, and livesDisplay=011 once the window ends; without the macro livesDisplay=011 throughout.
REQ-038 Scenario: reset pulse mid-INVULN at counter 30 -> all outputs are 0 immediately, and no transition occurs on later startOfFrame pulses until newGame.
